// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-outstanding imem requests, and an instruction/PC FIFO for decode.
// Define FETCH_PERF_EN to add the perf_fetch_cnt / perf_flush_cnt counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jmp_en,
  input  logic [31:0] jmp_addr,
  input  logic        clr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ins_valid,
  output logic [31:0] ins,
  output logic [31:0] ins_addr,
  input  logic        ins_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic            drop_q, drop_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]     data_q [FIFO_DEPTH];
  logic [31:0]     addr_q [FIFO_DEPTH];

  logic        flush;
  logic        accept;
  logic        push;
  logic        pop;
  logic [31:0] jmp_pc;

  assign flush  = jmp_en | clr;
  assign jmp_pc = jmp_addr & ALIGN_MASK;

  // Only RUN issues, so count < depth always leaves a slot for the response.
  assign imem_req  = !rst && (state_q == ST_RUN) && (count_q < CW'(FIFO_DEPTH));
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_ready;

  assign ins_valid = (count_q != '0);
  assign ins       = data_q[rd_ptr_q];
  assign ins_addr  = addr_q[rd_ptr_q];

  assign push = (state_q == ST_WAIT) && imem_rvalid && !drop_q && !flush;
  assign pop  = ins_valid && ins_ready && !flush;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    drop_d   = drop_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = ST_WAIT;
          drop_d   = flush;
        end
      end
      ST_WAIT: begin
        // A response arriving with a redirect is discarded outright, so no drop is left pending.
        if (imem_rvalid) begin
          state_d = ST_RUN;
          drop_d  = 1'b0;
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (jmp_en) begin
      pc_d = jmp_pc;
    end else if (clr) begin
      pc_d = pc_q;
    end

    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC & ALIGN_MASK;
      req_pc_q <= '0;
      drop_q   <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          data_q[gi] <= '0;
          addr_q[gi] <= '0;
        end else if (push && (wr_ptr_q == PW'(gi))) begin
          data_q[gi] <= imem_rdata;
          addr_q[gi] <= req_pc_q;
        end
      end
    end
  endgenerate

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q + 32'(push);
    perf_flush_d = perf_flush_q + 32'(flush);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
